display_share_arbiter: RTL and testbench
========================================

Name: display_share_arbiter

Overview:
- Shares the single 4-digit seven-segment display scanner between several requesters, e.g. a counter, a debug register and a keypad echo.
- Each requester presents a 16-bit hex word and a request.
- The block grants one requester at a time, round-robin, with a guaranteed minimum on-screen time.
- It drives the scanner's 16-bit data input and shows a fixed idle pattern when nobody requests.

Parameters:
- NREQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 100_000_000, minimum clocks a granted word stays on screen (1 s at 100 MHz).
- CNT_W, 27, hold counter width; must satisfy 2^CNT_W > HOLD_CYCLES.
- IDLE_PATTERN, 16'h0000, word shown when no requester is granted.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request, level-sensitive.
- data_in  in  16*NREQ  requester i word at bits [16i+15:16i].
- grant  out  NREQ  one-hot or zero; registered.
- disp_data  out  16  word to the display scanner; registered.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, grant=0, disp_data=IDLE_PATTERN, busy=0.
  - hold counter=0, round-robin pointer last=NREQ-1, so req[0] has top priority on the first arbitration.
- States are IDLE, HOLD and SWITCH.
- IDLE:
  - grant=0, disp_data=IDLE_PATTERN.
  - If req!=0, pick the winner, go to HOLD next edge, set grant, clear the counter, set last=winner.
- HOLD:
  - Counter increments every clock. Expiry is counter==HOLD_CYCLES-1.
  - If req[owner] drops at any point, go to SWITCH next edge. This early release is allowed and overrides the hold.
  - At expiry with req[owner] still high:
    - If any other req is high, go to SWITCH.
    - Otherwise stay in HOLD, reset the counter to 0 and keep grant. Re-grant is seamless, with no bubble.
  - Before expiry, other requests are ignored (no pre-emption).
- SWITCH (exactly one cycle):
  - grant=0, disp_data holds its last value, so there is no idle flash between owners.
  - If req!=0, go to HOLD with the round-robin winner. Otherwise go to IDLE.
- Round-robin pick:
  - First requester with req high, searching from index last+1 upward modulo NREQ.
  - Combinational from req and last; the result is registered into grant.
- Latency:
  - A request seen at edge N in IDLE gives grant at N+1.
  - disp_data is registered from data_in of the granted index each cycle, so it shows the owner's word at N+2.
  - Owner data changes while granted appear on disp_data 1 cycle later, i.e. data tracks live.
- Simultaneous events:
  - An owner dropping req on the expiry cycle is treated as a drop and goes to SWITCH.
  - Requests arriving during SWITCH are included in that cycle's pick.
- A request pulse shorter than 1 cycle between edges is not guaranteed to be seen.
- Reset mid-HOLD forces IDLE immediately (async). The pointer returns to NREQ-1.
- Counter saturation cannot occur because it clears on expiry and on every grant.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, HOLD=2'd1, SWITCH=2'd2) and the default IDLE_PATTERN constant.
- One sub-module, rr_pick: a combinational round-robin selector.
  - Inputs: req[NREQ-1:0] and last index.
  - Outputs: found, winner index and one-hot vector.
- The FSM, hold counter and data mux stay in the top module.

Test Plan (NREQ=4, HOLD_CYCLES=8, IDLE_PATTERN=16'h0000):
- After rst=1 then 0 with req=0:
  - grant=0, disp_data=16'h0000, busy=0.
  - Assert rst mid-HOLD: grant=0 in the same cycle, busy=0.
- req=4'b0001 with data0=16'h1234 (edge N) → grant=4'b0001 at N+1, disp_data=16'h1234 at N+2. Holding req keeps grant indefinitely with no SWITCH cycle.
- req=4'b0101 held constant → grants alternate 0001, 0000 (SWITCH), 0100, 0000, 0001, …
  - Each owner keeps its grant for exactly 8 cycles.
  - disp_data never equals 16'h0000 between owners.
- Owner 1 granted, req[1] drops at hold count 3 with req[3]=1 → SWITCH next edge, then grant=4'b1000 one cycle later.
- req=4'b1111 for 40 cycles starting from reset → grant order 0, 1, 2, 3, 0. No requester is granted twice before all others have had a turn.
- While owner 2 is granted, change data2 from 16'hABCD to 16'h00FF → disp_data follows 1 cycle later and grant is unchanged.

Source files
------------

// File: rtl/display_share_arbiter_pkg.sv
// Shared definitions for the display share arbiter: FSM state encoding and
// the default word shown while no requester owns the display.
package display_share_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      SWITCH = 2'd2
   } arb_state_t;

   localparam logic [15:0] DEFAULT_IDLE_PATTERN = 16'h0000;

endpackage

// File: rtl/display_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request searching
// upward from last+1, wrapping modulo NREQ.
module display_share_arbiter_rr_pick #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last,
   output logic             found,
   output logic [IDX_W-1:0] winner,
   output logic [NREQ-1:0]  onehot
);

   int unsigned idx;

   // Scan candidates in priority order starting just after the last owner
   always_comb begin
      found  = 1'b0;
      winner = '0;
      onehot = '0;
      idx    = 0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = (32'(last) + k) % NREQ;
         if (!found && req[IDX_W'(idx)]) begin
            found                 = 1'b1;
            winner                = IDX_W'(idx);
            onehot[IDX_W'(idx)]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/display_share_arbiter.sv
// Shares one 4-digit seven-segment scanner between NREQ requesters:
// round-robin grant with a guaranteed minimum on-screen time, a one-cycle
// SWITCH gap between owners, and an idle word when nobody requests.
module display_share_arbiter
   import display_share_arbiter_pkg::*;
#(
   parameter int unsigned NREQ         = 4,
   parameter int unsigned HOLD_CYCLES  = 100_000_000,
   parameter int unsigned CNT_W        = 27,
   parameter logic [15:0] IDLE_PATTERN = DEFAULT_IDLE_PATTERN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [16*NREQ-1:0] data_in,
   output logic [NREQ-1:0]    grant,
   output logic [15:0]        disp_data,
   output logic               busy
);

   localparam int unsigned     IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [NREQ-1:0]  grant_q, grant_d;
   logic [15:0]      disp_q, disp_d;
   logic             busy_q, busy_d;

   logic             pick_found;
   logic [IDX_W-1:0] pick_winner;
   logic [NREQ-1:0]  pick_onehot;
   logic             owner_req;
   logic             others_req;
   logic [15:0]      owner_word;

   display_share_arbiter_rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req    (req),
      .last   (last_q),
      .found  (pick_found),
      .winner (pick_winner),
      .onehot (pick_onehot)
   );

   // last_q doubles as the owner index while in HOLD
   assign owner_req  = req[last_q];
   assign others_req = |(req & ~grant_q);
   assign owner_word = data_in[{last_q, 4'b0000} +: 16];

   // Next-state, hold counter, grant and display word selection
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      grant_d = grant_q;
      disp_d  = disp_q;
      unique case (state_q)
         IDLE: begin
            disp_d  = IDLE_PATTERN;
            grant_d = '0;
            if (pick_found) begin
               state_d = HOLD;
               grant_d = pick_onehot;
               last_d  = pick_winner;
               cnt_d   = '0;
            end
         end
         HOLD: begin
            disp_d = owner_word;
            if (!owner_req) begin
               state_d = SWITCH;
               grant_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               if (others_req) begin
                  state_d = SWITCH;
                  grant_d = '0;
               end else begin
                  cnt_d = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SWITCH: begin
            // disp_d keeps the previous owner's word so no idle flash appears
            if (pick_found) begin
               state_d = HOLD;
               grant_d = pick_onehot;
               last_d  = pick_winner;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            disp_d  = IDLE_PATTERN;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and registered outputs, asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= LAST_RST;
         grant_q <= '0;
         disp_q  <= IDLE_PATTERN;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         disp_q  <= disp_d;
         busy_q  <= busy_d;
      end
   end

   assign grant     = grant_q;
   assign disp_data = disp_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_display_share_arbiter.sv
// Directed bench for display_share_arbiter with NREQ=4, HOLD_CYCLES=8.
module tb_display_share_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [63:0] data_in;
   logic [3:0]  grant;
   logic [15:0] disp_data;
   logic        busy;

   int unsigned tests;
   int unsigned failed;

   display_share_arbiter #(
      .NREQ         (4),
      .HOLD_CYCLES  (8),
      .CNT_W        (4),
      .IDLE_PATTERN (16'h0000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data_in   (data_in),
      .grant     (grant),
      .disp_data (disp_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   logic [3:0]  exp_g;
   logic [15:0] exp_d;
   int unsigned pos;

   initial begin
      tests   = 0;
      failed  = 0;
      rst     = 1'b1;
      req     = '0;
      data_in = '0;

      // Reset state
      do_reset();
      chk("rst_grant", 16'(grant), 16'h0);
      chk("rst_disp", disp_data, 16'h0000);
      chk("rst_busy", 16'(busy), 16'h0);

      // Single requester: latency and seamless re-grant
      data_in[15:0] = 16'h1234;
      req = 4'b0001;
      tick();
      chk("lat_grant", 16'(grant), 16'h1);
      chk("lat_busy", 16'(busy), 16'h1);
      chk("lat_disp_early", disp_data, 16'h0000);
      tick();
      chk("lat_disp", disp_data, 16'h1234);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("solo_grant", 16'(grant), 16'h1);
         chk("solo_disp", disp_data, 16'h1234);
      end

      // Asynchronous reset in the middle of HOLD
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_grant", 16'(grant), 16'h0);
      chk("async_rst_busy", 16'(busy), 16'h0);
      chk("async_rst_disp", disp_data, 16'h0000);
      req = '0;
      tick();
      rst = 1'b0;
      tick();

      // Two requesters alternating, 8-cycle holds with SWITCH gaps
      data_in[15:0]  = 16'h1111;
      data_in[47:32] = 16'h2222;
      req = 4'b0101;
      for (int c = 0; c < 36; c++) begin
         tick();
         pos   = c % 18;
         exp_g = (pos < 8) ? 4'b0001 : (pos == 8) ? 4'b0000 :
                 (pos < 17) ? 4'b0100 : 4'b0000;
         if (c == 0)
            exp_d = 16'h0000;
         else
            exp_d = (pos >= 1 && pos <= 9) ? 16'h1111 : 16'h2222;
         chk("alt_grant", 16'(grant), 16'(exp_g));
         chk("alt_disp", disp_data, exp_d);
      end

      // Early release by owner 1 while requester 3 waits
      do_reset();
      data_in[31:16] = 16'h3333;
      data_in[63:48] = 16'h4444;
      req = 4'b0010;
      tick();
      chk("drop_grant0", 16'(grant), 16'h2);
      req = 4'b1010;
      tick();
      tick();
      tick();
      chk("drop_no_preempt", 16'(grant), 16'h2);
      req = 4'b1000;
      tick();
      chk("drop_switch", 16'(grant), 16'h0);
      chk("drop_switch_busy", 16'(busy), 16'h1);
      chk("drop_switch_disp", disp_data, 16'h3333);
      tick();
      chk("drop_next", 16'(grant), 16'h8);

      // All four requesting: fair rotation 0,1,2,3,0
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 40; c++) begin
         tick();
         pos   = c % 9;
         exp_g = (pos < 8) ? 4'(1 << ((c / 9) % 4)) : 4'b0000;
         chk("rr_grant", 16'(grant), 16'(exp_g));
      end

      // Live data tracking for the current owner, then release to IDLE
      do_reset();
      data_in[47:32] = 16'hABCD;
      req = 4'b0100;
      tick();
      chk("live_grant", 16'(grant), 16'h4);
      tick();
      chk("live_disp0", disp_data, 16'hABCD);
      data_in[47:32] = 16'h00FF;
      #1;
      chk("live_disp_pre", disp_data, 16'hABCD);
      tick();
      chk("live_disp1", disp_data, 16'h00FF);
      chk("live_grant1", 16'(grant), 16'h4);
      req = 4'b0000;
      tick();
      chk("rel_switch_grant", 16'(grant), 16'h0);
      chk("rel_switch_busy", 16'(busy), 16'h1);
      chk("rel_switch_disp", disp_data, 16'h00FF);
      tick();
      chk("rel_idle_busy", 16'(busy), 16'h0);
      tick();
      chk("rel_idle_disp", disp_data, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
